fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF stage of the 5-stage RV32I pipeline, directly upstream of the instruction ROM.
//  - Owns the PC and drives the ROM byte address; ROM read is combinational.
//  - Returns the instruction word in the same cycle and registers it, with its PC, into the IF/ID register.
//  - Handles stall, redirect (branch/jump from EX) and flush; substitutes NOPs for bubbles and out-of-window fetches.
// PARAMETERS
//  RESET_VECTOR  32'hBFC0_0000  first fetch address after reset; base of ROM window
//  ROM_BYTES     4096           ROM window size in bytes; fetches outside it fault
//  NOP_INSTR     32'h0000_0013  addi x0,x0,0, inserted on bubble/flush/fault
// PORTS
//  clk             in   1   rising-edge clock
//  rst             in   1   synchronous, active-high reset
//  imem_addr_o     out  32  byte address to ROM, equal to current PC (combinational)
//  imem_rd_i       in   32  instruction word from ROM for imem_addr_o, same cycle
//  stall_i         in   1   hazard unit: hold PC and IF/ID
//  redirect_i      in   1   EX: taken branch / JAL / JALR
//  redirect_pc_i   in   32  EX: target address
//  id_instr_o      out  32  IF/ID instruction
//  id_pc_o         out  32  IF/ID PC of that instruction
//  id_pc_plus4_o   out  32  IF/ID PC+4 (link value)
//  id_valid_o      out  1   IF/ID holds a real instruction
//  fetch_fault_o   out  1   registered: fetch address outside ROM window or misaligned target
// BEHAVIOUR
//  - Reset (sampled at clk edge):
//    - PC = RESET_VECTOR; id_instr_o = NOP_INSTR; id_pc_o = 0; id_pc_plus4_o = 0.
//    - id_valid_o = 0; fetch_fault_o = 0.
//    - Reset asserted mid-operation overrides stall and redirect in that cycle.
//  - imem_addr_o = PC at all times; no wait states; fetch latency is 1 cycle into IF/ID.
//  - Next-PC priority, highest first: rst > redirect_i > stall_i > PC+4.
//    - redirect_i: PC <= {redirect_pc_i[31:2],2'b00}; IF/ID flushed (instr=NOP_INSTR, valid=0),
//      even when stall_i=1 in the same cycle (the redirect kills the stalled younger instruction).
//    - redirect_pc_i[1:0] != 0: low bits cleared as above; fetch_fault_o = 1 for the next cycle.
//    - stall_i (no redirect): PC and all IF/ID outputs hold; fetch_fault_o holds.
//    - Otherwise: PC <= PC+4, modulo 2^32 (wraps 32'hFFFF_FFFC -> 0, no flag).
//  - IF/ID load (normal advance):
//    - id_pc_o <= PC; id_pc_plus4_o <= PC+4; id_valid_o <= in_window.
//    - in_window = PC >= RESET_VECTOR && PC <= RESET_VECTOR+ROM_BYTES-4 (32-bit unsigned compare).
//    - in_window: id_instr_o <= imem_rd_i; fetch_fault_o <= 0.
//    - Outside window: id_instr_o <= NOP_INSTR, valid=0, fetch_fault_o <= 1; PC still advances.
//  - No FSM beyond the valid bit: states {EMPTY(valid=0), FULL(valid=1)};
//    - EMPTY->FULL on in-window advance.
//    - FULL->EMPTY on redirect or out-of-window advance.
//    - FULL and EMPTY each hold on stall.
// STRUCTURE
//  - Shared package rv_pkg: RESET_VECTOR_DEF, NOP_INSTR_DEF, typedef logic [31:0] addr_t / instr_t,
//    typedef struct packed if_id_t {instr_t instr; addr_t pc; addr_t pc_plus4; logic valid;}.
//  - One sub-module, if_id_reg: IF/ID register with load/flush/hold controls and NOP reset value.
//  - Top level holds the PC register, next-PC mux, window check and fault flag.
// TESTING
//  1. rst=1 two cycles then release, ROM holds 0x00500093 at 0xBFC00000
//     -> imem_addr_o=0xBFC00000 during reset.
//     -> first post-reset edge: id_instr_o=0x00500093, id_pc_o=0xBFC00000, id_pc_plus4_o=0xBFC00004, valid=1.
//  2. Free-run 4 cycles -> imem_addr_o steps 0xBFC00000,04,08,0C; IF/ID trails by exactly one cycle.
//  3. stall_i=1 for 3 cycles at PC=0xBFC00008 -> PC and IF/ID unchanged all 3 cycles;
//     after release, next IF/ID pc_o=0xBFC00008.
//  4. redirect_i=1, redirect_pc_i=0xBFC00100 with stall_i=1 simultaneously
//     -> next cycle PC=0xBFC00100, id_valid_o=0, id_instr_o=0x00000013.
//  5. redirect_pc_i=0xBFC00102 -> PC=0xBFC00100, fetch_fault_o=1 for one cycle.
//     redirect_pc_i=0xBFC01000 (window end) -> next IF/ID: NOP, valid=0, fault=1; PC advances to 0xBFC01004.
//  6. rst=1 asserted while stall_i=1 and redirect_i=1 -> next cycle PC=0xBFC00000, valid=0, fault=0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I front-end types: address/instruction words, IF/ID payload, valid-bit states.
// Latency: n/a (types, constants and a pure combinational helper only).
// Backpressure: n/a.
package rv_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] instr_t;

  // Boot address; also the base of the instruction ROM window.
  localparam addr_t  RESET_VECTOR_DEF = 32'hBFC0_0000;
  // ROM window size in bytes.
  localparam int     ROM_BYTES_DEF    = 4096;
  // addi x0,x0,0 -- the canonical bubble.
  localparam instr_t NOP_INSTR_DEF    = 32'h0000_0013;

  // Contents of the IF/ID pipeline register.
  typedef struct packed {
    instr_t instr;
    addr_t  pc;
    addr_t  pc_plus4;
    logic   valid;
  } if_id_t;

  // The only state machine in the fetch stage: whether IF/ID holds a real instruction.
  typedef enum logic {
    ID_EMPTY = 1'b0,
    ID_FULL  = 1'b1
  } id_state_e;

  // Inclusive unsigned range check; 'last' is the address of the final word in the window.
  function automatic logic addr_in_window(input addr_t a, input addr_t base, input addr_t last);
    return (a >= base) && (a <= last);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load, flush and hold controls; resets to a NOP bubble.
// Latency: 1 cycle from d to q when load is high.
// Backpressure: load low holds every field; flush beats load and empties the register.
import rv_pkg::*;

module if_id_reg #(
  parameter instr_t NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  id_state_e state;
  id_state_e state_nxt;
  instr_t    instr_q;
  addr_t     pc_q;
  addr_t     pc_plus4_q;

  // Valid-bit state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ID_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Valid-bit next state: flush empties, load follows the incoming valid, otherwise hold.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ID_EMPTY;
    end else if (load) begin
      state_nxt = d.valid ? ID_FULL : ID_EMPTY;
    end
  end

  // Payload fields; a flush only needs to turn the instruction into a bubble, the PCs are don't-care.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q    <= NOP_INSTR;
      pc_q       <= '0;
      pc_plus4_q <= '0;
    end else if (flush) begin
      instr_q    <= NOP_INSTR;
    end else if (load) begin
      instr_q    <= d.instr;
      pc_q       <= d.pc;
      pc_plus4_q <= d.pc_plus4;
    end
  end

  assign q = '{instr: instr_q, pc: pc_q, pc_plus4: pc_plus4_q, valid: (state == ID_FULL)};

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, drives the combinational ROM address and loads IF/ID with the fetched word.
// Latency: instruction and its PC appear on the id_* outputs one cycle after the PC is presented.
// Backpressure: stall_i freezes PC, IF/ID and the fault flag; redirect_i overrides stall and flushes IF/ID.
import rv_pkg::*;

module fetch_stage #(
  parameter addr_t  RESET_VECTOR = RESET_VECTOR_DEF,
  parameter int     ROM_BYTES    = ROM_BYTES_DEF,
  parameter instr_t NOP_INSTR    = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rd_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_pc_plus4_o,
  output logic        id_valid_o,
  output logic        fetch_fault_o
);

  // Address of the last fetchable word in the ROM window.
  localparam addr_t WIN_LAST = RESET_VECTOR + addr_t'(ROM_BYTES) - 32'd4;

  addr_t  pc;
  addr_t  pc_nxt;
  addr_t  pc_plus4;
  addr_t  redirect_aligned;
  logic   redirect_misaligned;
  logic   in_window;
  logic   fault_q;
  if_id_t id_d;
  if_id_t id_q;

  // Wraps naturally at 2^32 with no flag.
  assign pc_plus4            = pc + 32'd4;
  assign redirect_aligned    = {redirect_pc_i[31:2], 2'b00};
  assign redirect_misaligned = |redirect_pc_i[1:0];
  assign in_window           = addr_in_window(pc, RESET_VECTOR, WIN_LAST);

  // Next-PC mux: redirect beats stall, stall beats sequential advance (reset handled in the register).
  always_comb begin
    pc_nxt = pc;
    if (redirect_i) begin
      pc_nxt = redirect_aligned;
    end else if (!stall_i) begin
      pc_nxt = pc_plus4;
    end
  end

  // PC register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_VECTOR;
    end else begin
      pc <= pc_nxt;
    end
  end

  // Fault flag: flags a misaligned redirect target, or an out-of-window fetch on advance; holds on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else if (redirect_i) begin
      fault_q <= redirect_misaligned;
    end else if (!stall_i) begin
      fault_q <= !in_window;
    end
  end

  // Out-of-window fetches become bubbles so garbage from the ROM bus never reaches decode.
  assign id_d = '{
    instr:    in_window ? imem_rd_i : NOP_INSTR,
    pc:       pc,
    pc_plus4: pc_plus4,
    valid:    in_window
  };

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk   (clk),
    .rst   (rst),
    .load  (!stall_i),
    .flush (redirect_i),
    .d     (id_d),
    .q     (id_q)
  );

  assign imem_addr_o   = pc;
  assign id_instr_o    = id_q.instr;
  assign id_pc_o       = id_q.pc;
  assign id_pc_plus4_o = id_q.pc_plus4;
  assign id_valid_o    = id_q.valid;
  assign fetch_fault_o = fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a combinational ROM model.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: stall and redirect driven directly from the test tasks.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        id_valid;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr_o   (imem_addr),
    .imem_rd_i     (imem_rd),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .id_instr_o    (id_instr),
    .id_pc_o       (id_pc),
    .id_pc_plus4_o (id_pc_plus4),
    .id_valid_o    (id_valid),
    .fetch_fault_o (fetch_fault)
  );

  // ROM contents: a known first word, then an address-tagged pattern.
  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h0050_0093;
    return {8'hA5, a[23:0]};
  endfunction

  assign imem_rd = rom(imem_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    tick();
    tick();
    checks++; if (imem_addr !== 32'hBFC0_0000) begin errors++; $display("FAIL rst_addr got=%h exp=%h", imem_addr, 32'hBFC0_0000); end
    checks++; if (id_instr !== NOP) begin errors++; $display("FAIL rst_instr got=%h exp=%h", id_instr, NOP); end
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got=%h exp=%h", id_pc, 32'h0); end
    checks++; if (id_pc_plus4 !== 32'h0) begin errors++; $display("FAIL rst_pc4 got=%h exp=%h", id_pc_plus4, 32'h0); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", id_valid); end
    checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL rst_fault got=%b exp=0", fetch_fault); end
    rst = 1'b0;
    tick();
    checks++; if (id_instr !== 32'h0050_0093) begin errors++; $display("FAIL first_instr got=%h exp=%h", id_instr, 32'h0050_0093); end
    checks++; if (id_pc !== 32'hBFC0_0000) begin errors++; $display("FAIL first_pc got=%h exp=%h", id_pc, 32'hBFC0_0000); end
    checks++; if (id_pc_plus4 !== 32'hBFC0_0004) begin errors++; $display("FAIL first_pc4 got=%h exp=%h", id_pc_plus4, 32'hBFC0_0004); end
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL first_valid got=%b exp=1", id_valid); end
    checks++; if (imem_addr !== 32'hBFC0_0004) begin errors++; $display("FAIL first_addr got=%h exp=%h", imem_addr, 32'hBFC0_0004); end
  endtask

  // PC is 0xBFC00004 on entry; advance once so the PC lands on 0xBFC00008.
  task automatic test_free_run();
    tick();
    checks++; if (imem_addr !== 32'hBFC0_0008) begin errors++; $display("FAIL run_addr got=%h exp=%h", imem_addr, 32'hBFC0_0008); end
    checks++; if (id_pc !== 32'hBFC0_0004) begin errors++; $display("FAIL run_pc got=%h exp=%h", id_pc, 32'hBFC0_0004); end
    checks++; if (id_instr !== 32'hA5C0_0004) begin errors++; $display("FAIL run_instr got=%h exp=%h", id_instr, 32'hA5C0_0004); end
    checks++; if (id_pc_plus4 !== 32'hBFC0_0008) begin errors++; $display("FAIL run_pc4 got=%h exp=%h", id_pc_plus4, 32'hBFC0_0008); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (imem_addr !== 32'hBFC0_0008) begin errors++; $display("FAIL stall_addr[%0d] got=%h exp=%h", i, imem_addr, 32'hBFC0_0008); end
      checks++; if (id_pc !== 32'hBFC0_0004) begin errors++; $display("FAIL stall_pc[%0d] got=%h exp=%h", i, id_pc, 32'hBFC0_0004); end
      checks++; if (id_instr !== 32'hA5C0_0004) begin errors++; $display("FAIL stall_instr[%0d] got=%h exp=%h", i, id_instr, 32'hA5C0_0004); end
      checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got=%b exp=1", i, id_valid); end
    end
    stall = 1'b0;
    tick();
    checks++; if (id_pc !== 32'hBFC0_0008) begin errors++; $display("FAIL unstall_pc got=%h exp=%h", id_pc, 32'hBFC0_0008); end
    checks++; if (id_instr !== 32'hA5C0_0008) begin errors++; $display("FAIL unstall_instr got=%h exp=%h", id_instr, 32'hA5C0_0008); end
    checks++; if (imem_addr !== 32'hBFC0_000C) begin errors++; $display("FAIL unstall_addr got=%h exp=%h", imem_addr, 32'hBFC0_000C); end
  endtask

  task automatic test_redirect_stall();
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'hBFC0_0100;
    tick();
    checks++; if (imem_addr !== 32'hBFC0_0100) begin errors++; $display("FAIL redir_addr got=%h exp=%h", imem_addr, 32'hBFC0_0100); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL redir_valid got=%b exp=0", id_valid); end
    checks++; if (id_instr !== NOP) begin errors++; $display("FAIL redir_instr got=%h exp=%h", id_instr, NOP); end
    checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL redir_fault got=%b exp=0", fetch_fault); end
    stall = 1'b0; redirect = 1'b0;
    tick();
    checks++; if (id_pc !== 32'hBFC0_0100) begin errors++; $display("FAIL after_redir_pc got=%h exp=%h", id_pc, 32'hBFC0_0100); end
    checks++; if (id_instr !== 32'hA5C0_0100) begin errors++; $display("FAIL after_redir_instr got=%h exp=%h", id_instr, 32'hA5C0_0100); end
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL after_redir_valid got=%b exp=1", id_valid); end
  endtask

  task automatic test_misaligned();
    redirect = 1'b1; redirect_pc = 32'hBFC0_0102;
    tick();
    checks++; if (imem_addr !== 32'hBFC0_0100) begin errors++; $display("FAIL mis_addr got=%h exp=%h", imem_addr, 32'hBFC0_0100); end
    checks++; if (fetch_fault !== 1'b1) begin errors++; $display("FAIL mis_fault got=%b exp=1", fetch_fault); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL mis_valid got=%b exp=0", id_valid); end
    redirect = 1'b0;
    tick();
    checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL mis_fault_clear got=%b exp=0", fetch_fault); end
    checks++; if (id_pc !== 32'hBFC0_0100) begin errors++; $display("FAIL mis_id_pc got=%h exp=%h", id_pc, 32'hBFC0_0100); end
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL mis_id_valid got=%b exp=1", id_valid); end
  endtask

  // Last in-window word, then the first word past the window, then a stall holding the fault.
  task automatic test_window_end();
    redirect = 1'b1; redirect_pc = 32'hBFC0_0FFC;
    tick();
    checks++; if (imem_addr !== 32'hBFC0_0FFC) begin errors++; $display("FAIL win_addr got=%h exp=%h", imem_addr, 32'hBFC0_0FFC); end
    redirect = 1'b0;
    tick();
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL win_last_valid got=%b exp=1", id_valid); end
    checks++; if (id_instr !== 32'hA5C0_0FFC) begin errors++; $display("FAIL win_last_instr got=%h exp=%h", id_instr, 32'hA5C0_0FFC); end
    checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL win_last_fault got=%b exp=0", fetch_fault); end
    checks++; if (imem_addr !== 32'hBFC0_1000) begin errors++; $display("FAIL win_end_addr got=%h exp=%h", imem_addr, 32'hBFC0_1000); end
    tick();
    checks++; if (id_instr !== NOP) begin errors++; $display("FAIL oow_instr got=%h exp=%h", id_instr, NOP); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL oow_valid got=%b exp=0", id_valid); end
    checks++; if (fetch_fault !== 1'b1) begin errors++; $display("FAIL oow_fault got=%b exp=1", fetch_fault); end
    checks++; if (id_pc !== 32'hBFC0_1000) begin errors++; $display("FAIL oow_pc got=%h exp=%h", id_pc, 32'hBFC0_1000); end
    checks++; if (imem_addr !== 32'hBFC0_1004) begin errors++; $display("FAIL oow_addr got=%h exp=%h", imem_addr, 32'hBFC0_1004); end
    stall = 1'b1;
    tick();
    checks++; if (fetch_fault !== 1'b1) begin errors++; $display("FAIL oow_stall_fault got=%b exp=1", fetch_fault); end
    checks++; if (imem_addr !== 32'hBFC0_1004) begin errors++; $display("FAIL oow_stall_addr got=%h exp=%h", imem_addr, 32'hBFC0_1004); end
    stall = 1'b0;
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    tick();
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr got=%h exp=%h", imem_addr, 32'h0); end
    checks++; if (id_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc got=%h exp=%h", id_pc, 32'hFFFF_FFFC); end
    checks++; if (id_pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4 got=%h exp=%h", id_pc_plus4, 32'h0); end
    checks++; if (fetch_fault !== 1'b1) begin errors++; $display("FAIL wrap_fault got=%b exp=1", fetch_fault); end
  endtask

  task automatic test_reset_override();
    rst = 1'b1; stall = 1'b1; redirect = 1'b1; redirect_pc = 32'hBFC0_0200;
    tick();
    checks++; if (imem_addr !== 32'hBFC0_0000) begin errors++; $display("FAIL ovr_addr got=%h exp=%h", imem_addr, 32'hBFC0_0000); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL ovr_valid got=%b exp=0", id_valid); end
    checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL ovr_fault got=%b exp=0", fetch_fault); end
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL ovr_pc got=%h exp=%h", id_pc, 32'h0); end
    rst = 1'b0; stall = 1'b0; redirect = 1'b0;
    tick();
    checks++; if (id_instr !== 32'h0050_0093) begin errors++; $display("FAIL ovr_first_instr got=%h exp=%h", id_instr, 32'h0050_0093); end
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL ovr_first_valid got=%b exp=1", id_valid); end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_redirect_stall();
    test_misaligned();
    test_window_end();
    test_wrap();
    test_reset_override();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
